// File: rtl/mem_stage.sv
// Memory-access stage: decodes the EXE->MEM bus, runs loads/stores over a req/ack data-memory port.
// Optional misaligned-word trap enabled by defining MEM_ALIGN_CHECK_EN (adds the mem_ale port).
module mem_stage (
  input  logic         clk,
  input  logic         rst,
  input  logic         MEM_valid,
  input  logic [105:0] EXE_MEM_bus_r,
  output logic         dm_req,
  output logic [31:0]  dm_addr,
  output logic [3:0]   dm_wen,
  output logic [31:0]  dm_wdata,
  input  logic         dm_ack,
  input  logic [31:0]  dm_rdata,
  output logic         MEM_over,
  output logic [69:0]  MEM_WB_bus,
  output logic [31:0]  MEM_pc,
  output logic         mem_busy
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic         mem_ale
`endif
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t      state, state_nxt;
  logic        inst_load, inst_store, ls_word, lb_sign;
  logic [31:0] store_data, alu_result, pc, load_data, mem_result;
  logic        rf_wen, rf_wen_out, mem_inst, is_store, ld_en;
  logic [4:0]  rf_wdest;
  logic [3:0]  store_wen;
  logic [7:0]  ld_byte;

  assign {inst_load, inst_store, ls_word, lb_sign} = EXE_MEM_bus_r[105:102];
  assign store_data = EXE_MEM_bus_r[101:70];
  assign alu_result = EXE_MEM_bus_r[69:38];
  assign rf_wen     = EXE_MEM_bus_r[37];
  assign rf_wdest   = EXE_MEM_bus_r[36:32];
  assign pc         = EXE_MEM_bus_r[31:0];

  // A set load bit wins over a set store bit
  assign mem_inst  = inst_load | inst_store;
  assign is_store  = inst_store & ~inst_load;
  assign store_wen = ls_word ? 4'b1111 : (4'b0001 << alu_result[1:0]);

  assign dm_addr  = {alu_result[31:2], 2'b00};
  assign dm_wdata = ls_word ? store_data : {4{store_data[7:0]}};
  assign MEM_pc   = pc;

`ifdef MEM_ALIGN_CHECK_EN
  logic misalign;
  assign misalign = ls_word & (alu_result[1:0] != 2'b00);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) mem_ale <= 1'b0;
    else     mem_ale <= (state == IDLE) & MEM_valid & mem_inst & misalign;
  end

  assign rf_wen_out = rf_wen & ~mem_ale;
`else
  assign rf_wen_out = rf_wen;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    dm_req    = 1'b0;
    dm_wen    = 4'b0000;
    MEM_over  = 1'b0;
    mem_busy  = 1'b0;
    ld_en     = 1'b0;
    case (state)
      IDLE: begin
        if (MEM_valid) begin
          if (!mem_inst) MEM_over = 1'b1;
`ifdef MEM_ALIGN_CHECK_EN
          else if (misalign) state_nxt = DONE;
`endif
          else state_nxt = REQ;
        end
      end
      REQ: begin
        dm_req   = 1'b1;
        mem_busy = 1'b1;
        dm_wen   = is_store ? store_wen : 4'b0000;
        if (dm_ack) begin
          ld_en     = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        MEM_over  = 1'b1;
        mem_busy  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        load_data <= 32'd0;
    else if (ld_en) load_data <= dm_rdata;
  end

  // Byte lane pick and extension for byte loads
  always_comb begin
    case (alu_result[1:0])
      2'd0:    ld_byte = load_data[7:0];
      2'd1:    ld_byte = load_data[15:8];
      2'd2:    ld_byte = load_data[23:16];
      default: ld_byte = load_data[31:24];
    endcase
    if (!inst_load)   mem_result = alu_result;
    else if (ls_word) mem_result = load_data;
    else              mem_result = {{24{lb_sign & ld_byte[7]}}, ld_byte};
  end

  assign MEM_WB_bus = {rf_wen_out, rf_wdest, mem_result, pc};

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed cases plus random transactions against a spec-level model.
module tb_mem_stage;

  logic         clk = 1'b0;
  logic         rst;
  logic         MEM_valid;
  logic [105:0] EXE_MEM_bus_r;
  logic         dm_req;
  logic [31:0]  dm_addr;
  logic [3:0]   dm_wen;
  logic [31:0]  dm_wdata;
  logic         dm_ack;
  logic [31:0]  dm_rdata;
  logic         MEM_over;
  logic [69:0]  MEM_WB_bus;
  logic [31:0]  MEM_pc;
  logic         mem_busy;
`ifdef MEM_ALIGN_CHECK_EN
  logic         mem_ale;
`endif

  int checks = 0;
  int fails  = 0;

  mem_stage dut (
    .clk(clk), .rst(rst), .MEM_valid(MEM_valid), .EXE_MEM_bus_r(EXE_MEM_bus_r),
    .dm_req(dm_req), .dm_addr(dm_addr), .dm_wen(dm_wen), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata), .MEM_over(MEM_over), .MEM_WB_bus(MEM_WB_bus),
    .MEM_pc(MEM_pc), .mem_busy(mem_busy)
`ifdef MEM_ALIGN_CHECK_EN
    , .mem_ale(mem_ale)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [69:0] obs, input logic [69:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: expected write-back value straight from the load/store rules
  function automatic logic [31:0] ref_result(input logic [3:0] ctrl, input logic [31:0] alu,
                                             input logic [31:0] rdata);
    logic [7:0] b;
    if (!ctrl[3]) return alu;
    if (ctrl[1]) return rdata;
    b = 8'(rdata >> (8 * int'(alu[1:0])));
    if (ctrl[0] && b[7]) return 32'hFFFFFF00 | 32'(b);
    return 32'(b);
  endfunction

  function automatic logic [3:0] ref_wen(input logic [3:0] ctrl, input logic [31:0] alu);
    if (!(ctrl[2] && !ctrl[3])) return 4'b0000;
    if (ctrl[1]) return 4'b1111;
    return 4'(1 << int'(alu[1:0]));
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bus(input logic [3:0] ctrl, input logic [31:0] sdata, input logic [31:0] alu,
                           input logic rfw, input logic [4:0] dest, input logic [31:0] pc);
    EXE_MEM_bus_r = {ctrl, sdata, alu, rfw, dest, pc};
    MEM_valid = 1'b1;
  endtask

  task automatic do_nonmem(input logic [31:0] alu, input logic rfw, input logic [4:0] dest,
                           input logic [31:0] pc);
    next_cycle();
    drive_bus(4'b0000, $urandom, alu, rfw, dest, pc);
    #1;
    chk("nm_over", 70'(MEM_over), 70'(1'b1));
    chk("nm_req", 70'(dm_req), 70'(1'b0));
    chk("nm_bus", MEM_WB_bus, {rfw, dest, alu, pc});
    chk("nm_pc", 70'(MEM_pc), 70'(pc));
    next_cycle();
    MEM_valid = 1'b0;
    #1;
    chk("nm_over_drop", 70'(MEM_over), 70'(1'b0));
  endtask

  task automatic do_mem(input logic [3:0] ctrl, input logic [31:0] sdata, input logic [31:0] alu,
                        input logic rfw, input logic [4:0] dest, input logic [31:0] pc,
                        input int waits, input logic [31:0] rdata);
    logic [31:0] exp_wdata;
    int req_cycles;
    exp_wdata = ctrl[1] ? sdata : {4{sdata[7:0]}};
    req_cycles = 0;
    next_cycle();
    drive_bus(ctrl, sdata, alu, rfw, dest, pc);
    dm_ack = 1'b0;
    #1;
    chk("c0_over", 70'({MEM_over, dm_req, dm_wen}), 70'(6'b0));
    for (int w = 0; w <= waits; w++) begin
      next_cycle();
      if (dm_req) req_cycles++;
      chk("req_state", 70'({dm_req, mem_busy, MEM_over}), 70'(3'b110));
      chk("req_addr", 70'(dm_addr), 70'({alu[31:2], 2'b00}));
      chk("req_wen", 70'(dm_wen), 70'(ref_wen(ctrl, alu)));
      if (ctrl[2] && !ctrl[3]) chk("req_wdata", 70'(dm_wdata), 70'(exp_wdata));
      dm_ack   = (w == waits);
      dm_rdata = (w == waits) ? rdata : $urandom;
    end
    next_cycle();
    dm_ack = 1'b0;
    dm_rdata = $urandom;
    #1;
    chk("req_len", 70'(req_cycles), 70'(waits + 1));
    chk("done_state", 70'({dm_req, MEM_over, mem_busy, dm_wen}), 70'(7'b0110000));
    chk("done_bus", MEM_WB_bus, {rfw, dest, ref_result(ctrl, alu, rdata), pc});
    next_cycle();
    MEM_valid = 1'b0;
    #1;
    chk("after_idle", 70'({MEM_over, mem_busy, dm_req}), 70'(3'b000));
  endtask

  initial begin
    logic [3:0]  ctrl;
    logic [31:0] alu;
    rst = 1'b1;
    MEM_valid = 1'b0;
    EXE_MEM_bus_r = '0;
    dm_ack = 1'b0;
    dm_rdata = '0;
    repeat (2) next_cycle();
    chk("rst_outs", 70'({dm_req, dm_wen, MEM_over, mem_busy}), 70'(7'b0));
    rst = 1'b0;

    do_nonmem(32'h1234, 1'b1, 5'd3, 32'h0040_0000);
    do_mem(4'b1010, 32'h0, 32'h100, 1'b1, 5'd4, 32'h0040_0004, 3, 32'hDEADBEEF);
    do_mem(4'b1001, 32'h0, 32'h103, 1'b1, 5'd5, 32'h0040_0008, 0, 32'h80FF7F01);
    do_mem(4'b1000, 32'h0, 32'h103, 1'b1, 5'd6, 32'h0040_000C, 1, 32'h80FF7F01);
    do_mem(4'b0100, 32'h000000A5, 32'h202, 1'b0, 5'd0, 32'h0040_0010, 0, 32'h0);
    do_mem(4'b0110, 32'hCAFEF00D, 32'h300, 1'b0, 5'd0, 32'h0040_0014, 2, 32'h0);
    do_mem(4'b1110, 32'h12345678, 32'h404, 1'b1, 5'd7, 32'h0040_0018, 0, 32'h0BADF00D);

    // Reset while a load waits for its ack
    next_cycle();
    drive_bus(4'b1010, 32'h0, 32'h500, 1'b1, 5'd8, 32'h0040_001C);
    next_cycle();
    chk("pre_rst_req", 70'(dm_req), 70'(1'b1));
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async", 70'({dm_req, mem_busy, MEM_over}), 70'(3'b000));
    MEM_valid = 1'b0;
    next_cycle();
    rst = 1'b0;
    next_cycle();
    dm_ack = 1'b1;
    dm_rdata = 32'h11111111;
    #1;
    chk("late_ack", 70'({MEM_over, dm_req}), 70'(2'b00));
    next_cycle();
    dm_ack = 1'b0;
    #1;
    chk("late_ack2", 70'({MEM_over, dm_req, mem_busy}), 70'(3'b000));
    do_mem(4'b1010, 32'h0, 32'h600, 1'b1, 5'd9, 32'h0040_0020, 1, 32'h76543210);

`ifdef MEM_ALIGN_CHECK_EN
    next_cycle();
    drive_bus(4'b1010, 32'h0, 32'h102, 1'b1, 5'd10, 32'h0040_0024);
    #1;
    chk("ale_c0", 70'({MEM_over, dm_req}), 70'(2'b00));
    next_cycle();
    chk("ale_done", 70'({dm_req, MEM_over, mem_ale, MEM_WB_bus[69]}), 70'(4'b0110));
    next_cycle();
    MEM_valid = 1'b0;
    #1;
    chk("ale_clear", 70'({mem_ale, MEM_over, dm_req}), 70'(3'b000));
`endif

    for (int i = 0; i < 30; i++) begin
      int kind;
      kind = int'($urandom_range(0, 5));
      alu  = $urandom;
      case (kind)
        0: ctrl = 4'b0000;
        1: ctrl = 4'b1010;
        2: ctrl = {3'b100, 1'($urandom_range(0, 1))};
        3: ctrl = 4'b0110;
        4: ctrl = 4'b0100;
        default: ctrl = 4'b1110;
      endcase
`ifdef MEM_ALIGN_CHECK_EN
      if (ctrl[1]) alu[1:0] = 2'b00;
`endif
      if (kind == 0)
        do_nonmem(alu, 1'($urandom_range(0, 1)), 5'($urandom), $urandom);
      else
        do_mem(ctrl, $urandom, alu, ctrl[3], 5'($urandom), $urandom,
               int'($urandom_range(0, 3)), $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the multi-cycle CPU, directly downstream of the execute stage. Decodes the 106-bit EXE->MEM bus, runs loads and stores against a variable-latency data memory over a req/ack handshake, and sign- or zero-extends byte loads. Produces the 70-bit MEM->WB bus and a one-cycle completion pulse for the multi-cycle controller.

## Interface
- Parameters: none.
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- MEM_valid  in  1  stage valid from controller; held high until the cycle after MEM_over
- EXE_MEM_bus_r  in  106  registered EXE->MEM bus: [105:102] mem_control {inst_load, inst_store, ls_word, lb_sign}, [101:70] store_data, [69:38] alu_result, [37] rf_wen, [36:32] rf_wdest, [31:0] pc
- dm_req  out  1  data-memory request
- dm_addr  out  32  word address, {alu_result[31:2],2'b00}
- dm_wen  out  4  byte write enables; 0 for loads
- dm_wdata  out  32  store data
- dm_ack  in  1  memory accepted request; load data valid on dm_rdata in the same cycle
- dm_rdata  in  32  load data
- MEM_over  out  1  stage complete, one-cycle pulse
- MEM_WB_bus  out  70  {rf_wen, rf_wdest[4:0], mem_result[31:0], pc[31:0]}
- MEM_pc  out  32  pc of the instruction in this stage, for display
- mem_busy  out  1  high in REQ and DONE
- mem_ale  out  1  misaligned-word flag; present only with MEM_ALIGN_CHECK_EN

## Operation
- FSM states: IDLE, REQ, DONE. Reset state is IDLE.
- IDLE, MEM_valid=1, neither inst_load nor inst_store: MEM_over=1 combinationally in the same cycle. mem_result=alu_result. Stay in IDLE.
- IDLE, MEM_valid=1, inst_load or inst_store: go to REQ at the next edge. MEM_over=0.
- REQ: dm_req=1. Hold dm_addr, dm_wen and dm_wdata stable until dm_ack. When dm_ack=1, latch dm_rdata into load_data and go to DONE. Otherwise stay in REQ with no timeout.
- DONE: dm_req=0 and MEM_over=1. MEM_WB_bus carries the result. Return to IDLE at the next edge.
- Store enables:
  - word store: dm_wen=4'b1111, dm_wdata=store_data.
  - byte store: dm_wen=4'b0001<<alu_result[1:0], dm_wdata={4{store_data[7:0]}}.
- Load result:
  - word load: mem_result=load_data.
  - byte load: select byte lane alu_result[1:0], then sign-extend if lb_sign=1, else zero-extend.
  - For stores, mem_result=alu_result and rf_wen passes through unchanged (0 from decode).
- MEM_pc=pc at all times.
- If inst_load and inst_store are both set, treat the instruction as a load.
- Reset asserted mid-transaction: state goes to IDLE and dm_req drops immediately, asynchronously. The in-flight access is abandoned, and a late dm_ack in IDLE is ignored.
- dm_ack in IDLE or DONE is ignored.

## Timing
- Reset values: state IDLE, dm_req 0, dm_wen 0, load_data 0, MEM_over 0, mem_busy 0, mem_ale 0.
- Non-memory instruction: 0-cycle latency. MEM_over is asserted in the cycle MEM_valid is seen.
- Memory instruction with dm_ack in the first REQ cycle: MEM_valid at cycle 0, dm_req at cycle 1, MEM_over at cycle 2.
- Each extra wait cycle on dm_ack adds one cycle.
- dm_wen is non-zero only while in REQ. A store is committed in the single cycle where dm_req & dm_ack are both high.
- MEM_over is high for exactly one cycle per instruction.

## Configuration
- Macro: MEM_ALIGN_CHECK_EN.
- Defined: a word access (ls_word=1) with alu_result[1:0]!=0 issues no request. FSM goes IDLE->DONE, with mem_ale=1 and MEM_over=1 in DONE. The rf_wen field of MEM_WB_bus is forced to 0.
- Not defined: the mem_ale port is absent. alu_result[1:0] is ignored for word accesses, so the access uses the word-aligned dm_addr.

## Test plan
- ADD-type bus (mem_control=0, alu_result=0x1234), MEM_valid=1 -> MEM_over=1 in the same cycle, mem_result=0x1234, dm_req never asserted.
- lw addr 0x100, dm_ack after 3 wait cycles, dm_rdata=0xDEADBEEF -> dm_req high for 4 cycles, MEM_over on the cycle after ack, mem_result=0xDEADBEEF.
- lb addr 0x103, lb_sign=1, dm_rdata=0x80FF7F01 -> mem_result=0xFFFFFF80. Same access with lb_sign=0 -> 0x00000080.
- sb addr 0x202, store_data=0x000000A5, immediate ack -> dm_wen=4'b0100, dm_wdata=0xA5A5A5A5, dm_addr=0x200.
- rst asserted during REQ with ack pending -> dm_req=0 immediately. A subsequent dm_ack pulse produces no MEM_over. The next lw completes normally.
- With MEM_ALIGN_CHECK_EN: lw addr 0x102 -> no dm_req, mem_ale=1 and MEM_over=1 one cycle after MEM_valid, MEM_WB_bus rf_wen=0.
